// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply, restoring divide on
// magnitudes with a final sign-fix step. Results are held in the Hi/Lo registers.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [2:0]       state_dbg
);
    // Handshake: start is accepted only in IDLE, outside the done cycle, with op MULT or
    // DIV; a/b are captured on that edge. done pulses once, hi/lo/div_zero valid from then.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        FINISH   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_MULT = 2'd1,
        SEL_DIV  = 2'd2
    } sel_t;

    localparam logic [1:0]       OP_MULT  = 2'b01;
    localparam logic [1:0]       OP_DIV   = 2'b10;
    localparam int               CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t               state_q, state_d;
    sel_t                 sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sq_q, sq_d;
    logic                 sr_q, sr_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dz_q, dz_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       upper_ext, m_ext, booth_sum;
    logic [WIDTH:0]       rem_sh, trial;

    assign accept = (state_q == IDLE) && start && !done_q && ((op == OP_MULT) || (op == OP_DIV));

    // Magnitudes as unsigned values, so the most negative operand maps to 2^(WIDTH-1).
    assign a_mag = a[WIDTH-1] ? (~a + ONE) : a;
    assign b_mag = b[WIDTH-1] ? (~b + ONE) : b;

    // Booth step runs on WIDTH+1 bits so a most-negative multiplicand cannot overflow.
    assign upper_ext = {p_q[2*WIDTH], p_q[2*WIDTH:WIDTH+1]};
    assign m_ext     = {m_q[WIDTH-1], m_q};

    always_comb begin
        case (p_q[1:0])
            2'b01:   booth_sum = upper_ext + m_ext;
            2'b10:   booth_sum = upper_ext - m_ext;
            default: booth_sum = upper_ext;
        endcase
    end

    assign rem_sh = {rem_q, quot_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MULT)   state_d = MULT_RUN;
                    else if (b == '0)    state_d = FINISH;
                    else                 state_d = DIV_RUN;
                end
            end
            MULT_RUN: if (cnt_q == CNT_LAST) state_d = FINISH;
            DIV_RUN:  if (cnt_q == CNT_LAST) state_d = DIV_FIX;
            DIV_FIX:  state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        p_d    = p_q;
        m_d    = m_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        sq_d   = sq_q;
        sr_d   = sr_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        done_d = (state_q == FINISH);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (op == OP_MULT) begin
                        p_d   = {{WIDTH{1'b0}}, b, 1'b0};
                        m_d   = a;
                        sel_d = SEL_MULT;
                    end else if (b == '0) begin
                        dz_d  = 1'b1;
                        sel_d = SEL_NONE;
                    end else begin
                        sq_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        sr_d   = a[WIDTH-1];
                        rem_d  = '0;
                        quot_d = a_mag;
                        dvs_d  = b_mag;
                        sel_d  = SEL_DIV;
                    end
                end
            end
            MULT_RUN: begin
                p_d   = {booth_sum, p_q[WIDTH:1]};
                cnt_d = cnt_q + CNT_ONE;
            end
            DIV_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
            end
            DIV_FIX: begin
                quot_d = sq_q ? (~quot_q + ONE) : quot_q;
                rem_d  = sr_q ? (~rem_q + ONE) : rem_q;
            end
            FINISH: begin
                if (sel_q == SEL_MULT) begin
                    hi_d = p_q[2*WIDTH:WIDTH+1];
                    lo_d = p_q[WIDTH:1];
                end else if (sel_q == SEL_DIV) begin
                    hi_d = rem_q;
                    lo_d = quot_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= SEL_NONE;
            cnt_q  <= '0;
            p_q    <= '0;
            m_q    <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            sq_q   <= 1'b0;
            sr_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            p_q    <= p_d;
            m_q    <= m_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
            sq_q   <= sq_d;
            sr_q   <= sr_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        busy      = (state_q == MULT_RUN) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
        done      = done_q;
        hi        = hi_q;
        lo        = lo_q;
        div_zero  = dz_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a 64-bit arithmetic model feeds a scoreboard
// that is compared against hi/lo/div_zero, latency and busy behaviour.
module tb_mult_div_unit;
    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [2:0]   state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    logic         exp_dz_q[$];
    int           exp_lat_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
        .state_dbg(state_dbg)
    );

    // Drive one operation, push its expected result, wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int glitch_k, output int lat, output int busy_cnt, output logic ovl);
        longint sa, sb, prod, q, r;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        if (o == OP_MULT) begin
            prod = sa * sb;
            model_hi = prod[63:32];
            model_lo = prod[31:0];
            exp_dz_q.push_back(1'b0);
            exp_lat_q.push_back(W + 1);
        end else if (vb == '0) begin
            exp_dz_q.push_back(1'b1);
            exp_lat_q.push_back(1);
        end else begin
            q = sa / sb;
            r = sa % sb;
            model_lo = q[31:0];
            model_hi = r[31:0];
            exp_dz_q.push_back(1'b0);
            exp_lat_q.push_back(W + 2);
        end
        exp_hi_q.push_back(model_hi);
        exp_lo_q.push_back(model_lo);

        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        lat = -1; busy_cnt = 0; ovl = 1'b0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (k == glitch_k) begin
                start = 1'b1; op = OP_DIV; a = $urandom; b = 32'($urandom_range(0, 3));
            end else if (k == glitch_k + 1) begin
                start = 1'b0;
            end
            if (busy && done) ovl = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (hi !== '0)        begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== '0)        begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        n_cmp++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
    endtask

    task automatic test_mult();
        logic [W-1:0] ta[6] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [W-1:0] tb[6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd1, 32'h0001_2345, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] va, vb, eh, el;
        logic ed, ovl;
        int lat, bc, elat;
        for (int i = 0; i < 12; i++) begin
            va = (i < 6) ? ta[i] : $urandom;
            vb = (i < 6) ? tb[i] : $urandom;
            run_op(OP_MULT, va, vb, -1, lat, bc, ovl);
            eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
            ed = exp_dz_q.pop_front(); elat = exp_lat_q.pop_front();
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d want %0d", i, lat, elat); end
            n_cmp++; if (hi !== eh) begin n_fail++; $display("FAIL mult_hi[%0d] %h*%h: got %h want %h", i, va, vb, hi, eh); end
            n_cmp++; if (lo !== el) begin n_fail++; $display("FAIL mult_lo[%0d] %h*%h: got %h want %h", i, va, vb, lo, el); end
            n_cmp++; if (div_zero !== ed) begin n_fail++; $display("FAIL mult_div_zero[%0d]: got %b want %b", i, div_zero, ed); end
            n_cmp++; if (bc !== elat - 1 || ovl) begin n_fail++; $display("FAIL mult_busy[%0d]: busy cycles %0d want %0d overlap %b", i, bc, elat - 1, ovl); end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] ta[6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100, 32'd1, 32'h8000_0000};
        logic [W-1:0] tb[6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [W-1:0] va, vb, eh, el;
        logic ed, ovl;
        int lat, bc, elat;
        for (int i = 0; i < 12; i++) begin
            va = (i < 6) ? ta[i] : $urandom;
            vb = (i < 6) ? tb[i] : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (vb == '0) vb = 32'd3;
            run_op(OP_DIV, va, vb, -1, lat, bc, ovl);
            eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
            ed = exp_dz_q.pop_front(); elat = exp_lat_q.pop_front();
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, elat); end
            n_cmp++; if (hi !== eh) begin n_fail++; $display("FAIL div_rem[%0d] %h/%h: got %h want %h", i, va, vb, hi, eh); end
            n_cmp++; if (lo !== el) begin n_fail++; $display("FAIL div_quot[%0d] %h/%h: got %h want %h", i, va, vb, lo, el); end
            n_cmp++; if (div_zero !== ed) begin n_fail++; $display("FAIL div_div_zero[%0d]: got %b want %b", i, div_zero, ed); end
            n_cmp++; if (bc !== elat - 1 || ovl) begin n_fail++; $display("FAIL div_busy[%0d]: busy cycles %0d want %0d overlap %b", i, bc, elat - 1, ovl); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] eh, el;
        logic ed, ovl;
        int lat, bc, elat;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) run_op(OP_DIV, 32'd5, 32'd0, -1, lat, bc, ovl);
            else        run_op(OP_MULT, $urandom, $urandom, -1, lat, bc, ovl);
            eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
            ed = exp_dz_q.pop_front(); elat = exp_lat_q.pop_front();
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL dz_latency[%0d]: got %0d want %0d", i, lat, elat); end
            n_cmp++; if (hi !== eh) begin n_fail++; $display("FAIL dz_hi[%0d]: got %h want %h", i, hi, eh); end
            n_cmp++; if (lo !== el) begin n_fail++; $display("FAIL dz_lo[%0d]: got %h want %h", i, lo, el); end
            n_cmp++; if (div_zero !== ed) begin n_fail++; $display("FAIL dz_flag[%0d]: got %b want %b", i, div_zero, ed); end
            n_cmp++; if (bc !== elat - 1 || ovl) begin n_fail++; $display("FAIL dz_busy[%0d]: busy cycles %0d want %0d overlap %b", i, bc, elat - 1, ovl); end
            if (i == 0) begin
                repeat (3) @(negedge clk);
                n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b want 1", div_zero); end
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] eh, el;
        logic ed, ovl, seen;
        int lat, bc, elat;
        logic [1:0] bad_ops[2] = '{2'b00, 2'b11};
        run_op(OP_MULT, 32'h0001_0003, 32'hFFFF_0101, 10, lat, bc, ovl);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
        ed = exp_dz_q.pop_front(); elat = exp_lat_q.pop_front();
        n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL glitch_latency: got %0d want %0d", lat, elat); end
        n_cmp++; if (hi !== eh) begin n_fail++; $display("FAIL glitch_hi: got %h want %h", hi, eh); end
        n_cmp++; if (lo !== el) begin n_fail++; $display("FAIL glitch_lo: got %h want %h", lo, el); end
        n_cmp++; if (div_zero !== ed) begin n_fail++; $display("FAIL glitch_div_zero: got %b want %b", div_zero, ed); end
        // Still in the done cycle here: a start now must be ignored.
        start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL start_in_done_cycle: activity %b want 0", seen); end
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; op = bad_ops[i]; a = $urandom; b = $urandom;
            @(negedge clk);
            start = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (busy || done) seen = 1'b1;
                @(negedge clk);
            end
            n_cmp++; if (seen !== 1'b0 || hi !== model_hi || lo !== model_lo)
                begin n_fail++; $display("FAIL bad_op[%0d]: activity %b hi %h lo %h want 0 %h %h", i, seen, hi, lo, model_hi, model_lo); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va, vb, eh, el;
        logic [1:0] o;
        logic ed, ovl;
        int lat, bc, elat;
        for (int i = 0; i < 6; i++) begin
            o = (i % 2 == 0) ? OP_MULT : OP_DIV;
            va = $urandom;
            vb = (i == 5) ? 32'd0 : $urandom;
            run_op(o, va, vb, -1, lat, bc, ovl);
            eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
            ed = exp_dz_q.pop_front(); elat = exp_lat_q.pop_front();
            n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, elat); end
            n_cmp++; if (hi !== eh || lo !== el) begin n_fail++; $display("FAIL b2b_result[%0d] op %0d %h,%h: got %h:%h want %h:%h", i, o, va, vb, hi, lo, eh, el); end
            n_cmp++; if (div_zero !== ed) begin n_fail++; $display("FAIL b2b_div_zero[%0d]: got %b want %b", i, div_zero, ed); end
        end
    endtask

    task automatic test_abort();
        logic seen;
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'h1234_5678; b = 32'h0FED_CBA9;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= 10; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_hi = '0; model_lo = '0;
        n_cmp++; if (hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL abort_hilo: got %h:%h want 0:0", hi, lo); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: busy %b done %b want 0 0", busy, done); end
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: activity %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        n_cmp++; if (exp_hi_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_hi_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit of the multicycle MIPS datapath. Sits directly downstream of the control FSM.
- Consumes div_mult_ctrl plus the A/B operand registers. Produces the Hi/Lo register contents and the div_zero flag that the FSM consumes.
- Multiply uses radix-2 Booth. Divide uses restoring division on magnitudes with a final sign-fix step.

Parameters:
WIDTH, 32, operand width; Hi/Lo each WIDTH bits; iteration count equals WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  sampled only in IDLE; launches the operation selected by op
op  in  2  div_mult_ctrl encoding: 00 none, 01 MULT, 10 DIV, 11 none
a  in  WIDTH  operand A (multiplicand / dividend), signed
b  in  WIDTH  operand B (multiplier / divisor), signed
hi  out  WIDTH  MULT: product[2*WIDTH-1:WIDTH]; DIV: remainder
lo  out  WIDTH  MULT: product[WIDTH-1:0]; DIV: quotient
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse; hi/lo/div_zero valid from this cycle
div_zero  out  1  divisor was zero on the last DIV; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
  - Reset asserted mid-operation aborts the operation with no result written.
- Accepted start: start=1 with op in {01,10} while in IDLE.
  - start with op 00/11, or in any non-IDLE state, is ignored with no effect on outputs.
- a and b are captured internally on the accepting edge (E0). Later changes on a/b do not affect the operation.
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, FINISH.
- IDLE -> MULT_RUN on accepted MULT:
  - Load product register P = {WIDTH'b0, a_mult? no: multiplier b in low half}, extra Booth bit q-1=0, counter=0, busy=1.
  - Precisely: P[2W:0] = {W'b0, b, 1'b0}; multiplicand M = a.
- MULT_RUN, once per cycle, for WIDTH cycles:
  - Examine P[1:0]. 01: add M to upper half. 10: subtract M from upper half. 00/11: no add.
  - Then arithmetic-shift P right by 1. Upper-half arithmetic is WIDTH+1 bits wide so that -2^(W-1) operands are handled.
  - counter increments each cycle; when counter==WIDTH-1, go to FINISH.
- IDLE -> DIV_RUN on accepted DIV with b!=0:
  - Store sign flags sq = a[W-1]^b[W-1] and sr = a[W-1].
  - Load |a| and |b| as unsigned WIDTH-bit magnitudes; |-2^(W-1)| = 2^(W-1).
  - Clear the remainder register; counter=0; busy=1.
- IDLE -> FINISH on accepted DIV with b==0:
  - div_zero=1; hi/lo unchanged.
  - done pulses at E0+1; busy is never asserted.
- DIV_RUN, once per cycle, for WIDTH cycles:
  - Shift {rem, quot} left by 1.
  - Trial subtraction rem - |b| on WIDTH+1 bits. If non-negative: keep the result and set quot[0]=1. Otherwise restore.
  - After the WIDTH-th iteration, go to DIV_FIX.
- DIV_FIX:
  - Negate quot if sq; negate rem if sr. Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^(W-1)/-1 yields lo=0x80000000, hi=0 (mod-2^W wrap, no flag).
  - Go to FINISH.
- FINISH (one cycle):
  - Write hi/lo (skipped for the div-by-zero path). done=1, busy=0. Return to IDLE next edge.
  - div_zero=0 on any FINISH reached via a valid operation.
- Latency from accepting edge E0 (done visible in the cycle after the listed edge):
  - MULT: done after edge E0+WIDTH+1.
  - DIV: done after edge E0+WIDTH+2.
  - DIV by zero: done after edge E0+1.
- busy=1 from after E0 until the edge that enters FINISH; busy and done are never high together.
- hi/lo hold their value outside FINISH, so the control FSM may read them any time after done.
- A start asserted in the same cycle as done (FINISH) is ignored. A start in the following IDLE cycle is accepted.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_zero=0.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. MULT a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> done 34 cycles after start; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIV a=5, b=0 -> done next cycle, div_zero=1, hi/lo keep prior values, busy never high; the next valid MULT clears div_zero.
- Start a MULT; at cycle 10 pulse start with op=10 and change a/b -> ignored, original product produced. Repeat, asserting reset at cycle 10 -> next cycle hi=lo=0, busy=0, no done pulse.
